// File: rtl/mult_operand_sequencer_if.sv
// Operand request and tagged result streams of the multiplier sequencer.
// The sequencer takes the slave side; the operand producer / result consumer takes the master side.
interface mult_operand_sequencer_if #(
    parameter int unsigned TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_a;
    logic [3:0]       in_b;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_product;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_product, out_tag
    );

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_product, out_tag
    );
endinterface

// File: rtl/mult_operand_sequencer.sv
// Feeds one operand pair at a time to the serial shift-add multiplier, times its fixed latency
// and queues tagged products in a small first-word fall-through FIFO.
module mult_operand_sequencer #(
    parameter int unsigned MUL_LAT    = 4,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned TAG_W      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    mult_operand_sequencer_if.slave  io,
    output logic                     mul_start,
    output logic [3:0]               mul_a,
    output logic [3:0]               mul_b,
    input  logic [7:0]               mul_product,
    output logic                     busy
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(MUL_LAT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StCapture} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mul_start_q;
    logic [3:0]       a_q, b_q;
    logic [TAG_W-1:0] tag_q;

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [7:0]       prod_mem [FIFO_DEPTH];
    logic [TAG_W-1:0] tag_mem  [FIFO_DEPTH];

    logic accept, push, pop;

    // A free slot is required up front, so a capture can never hit a full FIFO.
    assign io.in_ready = (state_q == StIdle) && (count_q < FULL_COUNT);
    assign accept      = io.in_valid && io.in_ready;
    assign push        = (state_q == StCapture);
    assign pop         = io.out_valid && io.out_ready;

    assign io.out_valid   = (count_q != '0);
    assign io.out_product = io.out_valid ? prod_mem[rd_ptr_q] : '0;
    assign io.out_tag     = io.out_valid ? tag_mem[rd_ptr_q] : '0;

    assign mul_start = mul_start_q;
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign busy      = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StStart;
            end
            StStart: begin
                state_d = StWait;
                cnt_d   = CNT_LOAD;
            end
            StWait: begin
                if (cnt_q == '0) state_d = StCapture;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StCapture: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mul_start_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            // The multiplier restarts on any start, so it may only be high in StStart.
            mul_start_q <= (state_d == StStart);
            if (accept) begin
                a_q   <= io.in_a;
                b_q   <= io.in_b;
                tag_q <= io.in_tag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            prod_mem[wr_ptr_q] <= mul_product;
            tag_mem[wr_ptr_q]  <= tag_q;
        end
    end
endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Self-checking bench for mult_operand_sequencer: directed scenarios plus random traffic,
// with a behavioural multiplier and an operation-level scoreboard.
module tb_mult_operand_sequencer;
    localparam int unsigned MUL_LAT    = 4;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned TAG_W      = 4;

    typedef struct {
        logic [7:0]       prod;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       mul_start;
    logic [3:0] mul_a, mul_b;
    logic [7:0] mul_product;
    logic       busy;

    mult_operand_sequencer_if #(.TAG_W(TAG_W)) bus ();

    mult_operand_sequencer #(
        .MUL_LAT   (MUL_LAT),
        .FIFO_DEPTH(FIFO_DEPTH),
        .TAG_W     (TAG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .io         (bus),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_product(mul_product),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: the product is only correct during the single cycle after MUL_LAT
    // iterations; any other cycle shows junk, and a start during a run is a protocol violation.
    int         m_rem        = 0;
    int         restart_viol = 0;
    logic [7:0] m_final      = 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem       <= 0;
            mul_product <= 8'h00;
        end else if (mul_start) begin
            if (m_rem != 0) restart_viol <= restart_viol + 1;
            m_rem       <= MUL_LAT;
            m_final     <= 8'(mul_a) * 8'(mul_b);
            mul_product <= 8'($urandom);
        end else if (m_rem > 1) begin
            m_rem       <= m_rem - 1;
            mul_product <= 8'($urandom);
        end else if (m_rem == 1) begin
            m_rem       <= 0;
            mul_product <= m_final;
        end else begin
            mul_product <= ~m_final;
        end
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         n_acc = 0;
    int         n_starts = 0;
    bit         last_acc = 1'b0;
    exp_t       exp_q[$];
    logic [7:0] got_q[$];
    logic [TAG_W-1:0] got_tag_q[$];
    int         acc_t[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock: score any pop against the model, advance, then record accepts and pulses.
    task automatic step();
        bit   acc, pop;
        exp_t e;
        acc    = !rst && bus.in_valid && bus.in_ready;
        pop    = !rst && bus.out_valid && bus.out_ready;
        e.prod = 8'(bus.in_a) * 8'(bus.in_b);
        e.tag  = bus.in_tag;
        if (pop) begin
            check("pop_has_pending_op", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check("model_product", 32'(bus.out_product), 32'(exp_q[0].prod));
                check("model_tag", 32'(bus.out_tag), 32'(exp_q[0].tag));
            end
            got_q.push_back(bus.out_product);
            got_tag_q.push_back(bus.out_tag);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
        if (acc) begin
            exp_q.push_back(e);
            n_acc++;
        end
        last_acc = acc;
        if (mul_start) n_starts++;
    endtask

    task automatic set_op(input logic [3:0] a, input logic [3:0] b, input logic [TAG_W-1:0] t);
        bus.in_a   = a;
        bus.in_b   = b;
        bus.in_tag = t;
    endtask

    task automatic accept_op(input logic [3:0] a, input logic [3:0] b,
                             input logic [TAG_W-1:0] t, input string name);
        int n;
        set_op(a, b, t);
        bus.in_valid = 1'b1;
        n = 0;
        while (n < 50) begin
            step();
            n++;
            if (last_acc) break;
        end
        check({name, "_accepted"}, 32'(last_acc), 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(input string name);
        int n;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            step();
            n++;
        end
        check({name, "_out_valid"}, 32'(bus.out_valid), 1);
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [TAG_W-1:0] t,
                          input int exp_prod, input string name);
        bus.out_ready = 1'b1;
        accept_op(a, b, t, name);
        wait_out_valid(name);
        check({name, "_product"}, 32'(bus.out_product), exp_prod);
        check({name, "_tag"}, 32'(bus.out_tag), 32'(t));
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx, n, lat, starts0;
        int exp_b2b[3];
        int exp_bp[3];

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_op(4'd0, 4'd0, '0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_mul_start", 32'(mul_start), 0);
        check("rst_mul_a", 32'(mul_a), 0);
        check("rst_mul_b", 32'(mul_b), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_product", 32'(bus.out_product), 0);
        check("rst_out_tag", 32'(bus.out_tag), 0);

        // Offers during reset must be ignored.
        set_op(4'd7, 4'd7, 4'd3);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ignores_offer_busy", 32'(busy), 0);
        check("rst_ignores_offer_start", 32'(mul_start), 0);
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 1);

        // Single op and its timing.
        bus.out_ready = 1'b1;
        starts0       = n_starts;
        accept_op(4'd13, 4'd11, 4'd5, "t1");
        check("t1_mul_start_high", 32'(mul_start), 1);
        check("t1_mul_a", 32'(mul_a), 13);
        check("t1_mul_b", 32'(mul_b), 11);
        check("t1_busy", 32'(busy), 1);
        check("t1_in_ready_low", 32'(bus.in_ready), 0);
        step();
        lat = 1;
        check("t1_mul_start_one_cycle", 32'(mul_start), 0);
        while (!bus.out_valid && lat < 40) begin
            step();
            lat++;
        end
        check("t1_latency", 32'(lat), 6);
        check("t1_product", 32'(bus.out_product), 143);
        check("t1_tag", 32'(bus.out_tag), 5);
        check("t1_start_pulses", 32'(n_starts - starts0), 1);
        step();
        check("t1_fifo_empty", 32'(bus.out_valid), 0);

        // Corner operands.
        run_op(4'd15, 4'd15, 4'd9, 225, "c15x15");
        run_op(4'd0, 4'd9, 4'd10, 0, "c0x9");
        run_op(4'd9, 4'd0, 4'd11, 0, "c9x0");
        run_op(4'd1, 4'd1, 4'd12, 1, "c1x1");

        // Back-to-back with in_valid held high.
        got_q.delete();
        got_tag_q.delete();
        exp_b2b       = '{12, 14, 25};
        bus.out_ready = 1'b1;
        set_op(4'd3, 4'd4, 4'd1);
        bus.in_valid  = 1'b1;
        idx = 0;
        n   = 0;
        while (idx < 3 && n < 60) begin
            step();
            n++;
            if (last_acc) begin
                acc_t[idx] = cyc;
                idx++;
                if (idx == 1)      set_op(4'd7, 4'd2, 4'd2);
                else if (idx == 2) set_op(4'd5, 4'd5, 4'd3);
                else               bus.in_valid = 1'b0;
            end
        end
        check("b2b_accepts", 32'(idx), 3);
        check("b2b_gap_1", 32'(acc_t[1] - acc_t[0]), 7);
        check("b2b_gap_2", 32'(acc_t[2] - acc_t[1]), 7);
        n = 0;
        while (got_q.size() < 3 && n < 40) begin
            step();
            n++;
        end
        check("b2b_results", 32'(got_q.size()), 3);
        for (int i = 0; i < got_q.size() && i < 3; i++)
            check("b2b_order", 32'(got_q[i]), 32'(exp_b2b[i]));

        // Backpressure: two fill the FIFO, the third waits for a pop.
        got_q.delete();
        got_tag_q.delete();
        exp_bp        = '{6, 20, 42};
        bus.out_ready = 1'b0;
        set_op(4'd2, 4'd3, 4'd1);
        bus.in_valid  = 1'b1;
        idx = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (last_acc) begin
                idx++;
                if (idx == 1) set_op(4'd4, 4'd5, 4'd2);
                else          set_op(4'd6, 4'd7, 4'd3);
            end
        end
        check("bp_accepts_while_full", 32'(idx), 2);
        check("bp_in_ready_low", 32'(bus.in_ready), 0);
        check("bp_busy_low", 32'(busy), 0);
        check("bp_head_product", 32'(bus.out_product), 6);
        check("bp_head_tag", 32'(bus.out_tag), 1);
        step();
        step();
        check("bp_hold_product", 32'(bus.out_product), 6);
        check("bp_hold_tag", 32'(bus.out_tag), 1);
        bus.out_ready = 1'b1;
        step();
        check("bp_in_ready_after_pop", 32'(bus.in_ready), 1);
        step();
        check("bp_third_accept", 32'(last_acc), 1);
        bus.in_valid = 1'b0;
        n = 0;
        while (got_q.size() < 3 && n < 40) begin
            step();
            n++;
        end
        check("bp_results", 32'(got_q.size()), 3);
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            check("bp_order_product", 32'(got_q[i]), 32'(exp_bp[i]));
            check("bp_order_tag", 32'(got_tag_q[i]), 32'(i + 1));
        end

        // Push and pop on the same edge.
        bus.out_ready = 1'b0;
        accept_op(4'd5, 4'd3, 4'd6, "pp_first");
        wait_out_valid("pp_first");
        accept_op(4'd2, 4'd7, 4'd7, "pp_second");
        repeat (5) step();
        check("pp_capture_busy", 32'(busy), 1);
        check("pp_old_head", 32'(bus.out_product), 15);
        bus.out_ready = 1'b1;
        step();
        check("pp_valid_kept", 32'(bus.out_valid), 1);
        check("pp_new_head_product", 32'(bus.out_product), 14);
        check("pp_new_head_tag", 32'(bus.out_tag), 7);
        step();
        check("pp_count_was_one", 32'(bus.out_valid), 0);

        // Reset while waiting on the multiplier with one queued result.
        bus.out_ready = 1'b0;
        accept_op(4'd3, 4'd3, 4'd8, "ra_first");
        wait_out_valid("ra_first");
        accept_op(4'd4, 4'd4, 4'd9, "ra_second");
        repeat (3) step();
        check("ra_busy_before", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("ra_mul_start", 32'(mul_start), 0);
        check("ra_mul_a", 32'(mul_a), 0);
        check("ra_mul_b", 32'(mul_b), 0);
        check("ra_busy", 32'(busy), 0);
        check("ra_out_valid", 32'(bus.out_valid), 0);
        check("ra_out_product", 32'(bus.out_product), 0);
        check("ra_out_tag", 32'(bus.out_tag), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        got_q.delete();
        repeat (10) step();
        check("ra_nothing_emitted", 32'(got_q.size()), 0);
        run_op(4'd6, 4'd6, 4'd10, 36, "ra_after");

        // Random traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_a      = 4'($urandom);
            bus.in_b      = 4'($urandom);
            bus.in_tag    = TAG_W'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) step();
        check("rand_all_delivered", 32'(exp_q.size()), 0);
        check("rand_fifo_empty", 32'(bus.out_valid), 0);

        check("no_start_during_run", 32'(restart_viol), 0);
        check("one_start_per_accept", 32'(n_starts), 32'(n_acc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mult_operand_sequencer.md
# mult_operand_sequencer

Upstream control stage for the 4-bit serial shift-add multiplier. It accepts operand pairs over a valid/ready interface and drives the multiplier's `start`/`a`/`b`. Because the multiplier has no done flag, the block times the fixed latency itself, then captures `product` into a small result FIFO. Downstream logic reads results, in order and tagged, over a second valid/ready interface.

## Interface
- `MUL_LAT`, default 4: multiplier iterations, i.e. cycles from the edge that samples `start` to the edge that produces the final product.
- `FIFO_DEPTH`, default 2: result FIFO entries. Must be a power of two, ≥ 2.
- `TAG_W`, default 4: width of the user tag carried with each operation.
- `clk  in  1`: clock.
- `rst  in  1`: reset, asynchronous, active-high. Also drives the multiplier's reset.
- `in_valid  in  1`: operand pair offered.
- `in_ready  out  1`: block can accept. Equals `state==IDLE && fifo_count<FIFO_DEPTH`.
- `in_a  in  4`: multiplicand.
- `in_b  in  4`: multiplier.
- `in_tag  in  TAG_W`: tag returned with the result.
- `mul_start  out  1`: one-cycle start pulse to the multiplier.
- `mul_a  out  4`: registered operand to the multiplier.
- `mul_b  out  4`: registered operand to the multiplier.
- `mul_product  in  8`: multiplier `product` output.
- `out_valid  out  1`: FIFO non-empty.
- `out_ready  in  1`: consumer accepts head entry.
- `out_product  out  8`: head result.
- `out_tag  out  TAG_W`: head tag.
- `busy  out  1`: `state!=IDLE`.

## Operation
- FSM states: IDLE, START, WAIT, CAPTURE. Only one operation is in flight at a time.
- IDLE: on `in_valid && in_ready` at an edge:
  - register `in_a`→`mul_a`, `in_b`→`mul_b`, `in_tag`→internal tag register;
  - set `mul_start`←1;
  - go to START.
- START: `mul_start` is high for exactly this cycle.
  - Next edge: `mul_start`←0, cnt←`MUL_LAT-1`, go to WAIT.
- WAIT: each edge, if cnt==0 go to CAPTURE, else cnt←cnt-1.
- CAPTURE: `mul_product` is final during this cycle.
  - Next edge: push {tag, `mul_product`} into the FIFO, go to IDLE.
- `mul_a`/`mul_b` hold their value until the next accept. `mul_start` is never asserted outside START. This is required because the multiplier restarts on any `start`.
- No arithmetic is performed here: `out_product` is exactly the 8-bit multiplier result. The largest value is 15×15=225, so there is no overflow.
- Result FIFO:
  - circular buffer with read/write pointers and a count of width clog2(FIFO_DEPTH)+1;
  - first-word fall-through: `out_product`/`out_tag` show the head entry combinationally whenever `out_valid`=1;
  - pop on `out_valid && out_ready`;
  - push and pop on the same edge leave the count unchanged and preserve order;
  - push never targets a full FIFO, because `in_ready` already requires a free slot and only one operation is in flight;
  - pop on empty is a no-op.
- Outputs hold stable while `out_valid`=1 and `out_ready`=0.
- `in_valid` may drop without having been accepted. Operands are sampled only on the handshake edge.

## Timing
- Reset values: state=IDLE, `mul_start`=0, `mul_a`=`mul_b`=0, tag=0, cnt=0, FIFO pointers/count=0, `out_valid`=0, `out_product`=0, `out_tag`=0, `busy`=0.
- `in_ready`=1 out of reset. Handshakes are ignored while `rst`=1.
- Latency: accept at edge T0 → `mul_start` high in cycle T0..T1 → multiplier loads at T1 → product final at T1+`MUL_LAT` → FIFO push at T1+`MUL_LAT`+1. With `MUL_LAT`=4, `out_valid` rises 6 cycles after the accept edge.
- Throughput: the next accept comes no earlier than 1 cycle after the push edge, so one operation per `MUL_LAT`+3 = 7 cycles.
- `in_ready` drops in the cycle after accept and returns in the cycle after the push, provided the FIFO is not full.
- Reset mid-operation (any state) aborts the in-flight operation and discards all FIFO contents. Nothing is emitted for the aborted operation.
- Full FIFO with `out_ready`=0: the block stays in IDLE with `in_ready`=0. It resumes the cycle after a pop.

## Test plan
- Single op: a=13, b=11, tag=5, with `out_ready`=1. Expect `mul_start` high for exactly 1 cycle, `out_valid` 6 cycles after accept, `out_product`=143, `out_tag`=5.
- Corner operands: (15,15)→225; (0,9)→0; (9,0)→0; (1,1)→1. Each result arrives with its own tag.
- Back-to-back: `in_valid` held high across 3 ops (3×4, 7×2, 5×5). Expect accepts exactly 7 cycles apart, results 12, 14, 25 in order, and `mul_start` never asserted during WAIT.
- Backpressure: `out_ready`=0, offer 3 ops. Expect 2 captured, then `in_ready`=0 with the third op pending. Raise `out_ready`: the third op is accepted the cycle after the first pop, and all three emerge in order with the correct tags.
- Simultaneous push/pop: FIFO holds 1 entry, `out_ready`=1 on the push edge. Expect count to stay 1 and the new entry to become head the next cycle.
- Reset in WAIT (cnt=1) with 1 entry in the FIFO. Expect all outputs at reset values immediately (async), no result emitted, and a clean 6×6=36 after reset release.
